// File: rtl/timer_edit_ctrl_pkg.sv
// Shared encodings for the timer edit sequencer: FSM states and the field-select
// codes understood by the timer hours/minutes/seconds counters.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EDIT_HH = 2'd1,
        ST_EDIT_MM = 2'd2,
        ST_EDIT_SS = 2'd3
    } state_e;

    localparam logic [3:0] FIELD_NONE = 4'd0;
    localparam logic [3:0] FIELD_T_HH = 4'd6;
    localparam logic [3:0] FIELD_T_MM = 4'd7;
    localparam logic [3:0] FIELD_T_SS = 4'd8;

    function automatic logic [3:0] field_of(input state_e st);
        case (st)
            ST_EDIT_HH: field_of = FIELD_T_HH;
            ST_EDIT_MM: field_of = FIELD_T_MM;
            ST_EDIT_SS: field_of = FIELD_T_SS;
            default:    field_of = FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/timer_edit_ctrl_if.sv
// Button levels in, field select and step strobes out. The button/panel side
// uses the master modport, the edit controller uses the slave modport.
interface timer_edit_ctrl_if;

    logic       btn_edit;
    logic       btn_right;
    logic       btn_left;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] contadoresH;
    logic       Arriba;
    logic       Abajo;
    logic       editing;

    modport master (
        output btn_edit, btn_right, btn_left, btn_up, btn_down,
        input  contadoresH, Arriba, Abajo, editing
    );

    modport slave (
        input  btn_edit, btn_right, btn_left, btn_up, btn_down,
        output contadoresH, Arriba, Abajo, editing
    );

endinterface

// File: rtl/timer_edit_ctrl_key_repeat.sv
// One step button: 2-FF synchronizer, rise detector and hold-to-auto-repeat
// engine producing registered one-cycle pulses.
module key_repeat #(
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 26_000_000,
    parameter int CNT_W         = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic enable,
    input  logic clear,
    output logic pulse,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]       vld_q, vld_d;
    logic             armed_q, armed_d;
    logic             active_q, active_d, rpt_q, rpt_d, pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A level already high when reset releases is never seen low, so it stays unarmed.
    assign rise  = sync2_q & ~prev_q & armed_q;
    assign level = sync2_q;
    assign pulse = pulse_q;

    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        vld_d    = {vld_q[0], 1'b1};
        armed_d  = armed_q | (vld_q[1] & ~sync2_q);
        active_d = active_q;
        rpt_d    = rpt_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (clear || !enable || !sync2_q) begin
            active_d = 1'b0;
            rpt_d    = 1'b0;
            cnt_d    = '0;
        end else if (rise) begin
            active_d = 1'b1;
            rpt_d    = 1'b0;
            cnt_d    = '0;
            pulse_d  = 1'b1;
        end else if (active_q) begin
            if (cnt_q == (rpt_q ? REP_LAST : HOLD_LAST)) begin
                pulse_d = 1'b1;
                rpt_d   = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            vld_q    <= 2'b00;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            rpt_q    <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            vld_q    <= vld_d;
            armed_q  <= armed_d;
            active_q <= active_d;
            rpt_q    <= rpt_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

endmodule

// File: rtl/timer_edit_ctrl.sv
// Edit-mode sequencer: selects which timer field is being set and issues
// Arriba/Abajo step strobes with auto-repeat; abandons edit after inactivity.
module timer_edit_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 26_000_000,
    parameter int TIMEOUT       = 1_000_000_000,
    parameter int CNT_W         = 30
) (
    input  logic              clk,
    input  logic              reset,
    timer_edit_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Navigation buttons, bit 0 = edit, bit 1 = right, bit 2 = left.
    logic [2:0]       nav_s1_q, nav_s1_d, nav_s2_q, nav_s2_d, nav_prev_q, nav_prev_d;
    logic [2:0]       nav_armed_q, nav_armed_d, nav_rise;
    logic [1:0]       nav_vld_q, nav_vld_d;
    state_e           state_q, state_d;
    logic [3:0]       field_q, field_d;
    logic             editing_q, editing_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    logic [1:0]       step_btn, step_pulse, step_level, step_rise;
    logic             step_enable, step_clear;

    assign step_btn    = {bus.btn_down, bus.btn_up};
    assign nav_rise    = nav_s2_q & ~nav_prev_q & nav_armed_q;
    assign step_enable = (state_q != ST_IDLE);
    // Both held, or any field change/exit, drops both engines so a fresh rise is required.
    assign step_clear  = (&step_level) | (state_d != state_q);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_step
            key_repeat #(
                .HOLD_DELAY    (HOLD_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .CNT_W         (CNT_W)
            ) u_key (
                .clk    (clk),
                .reset  (reset),
                .btn    (step_btn[gi]),
                .enable (step_enable),
                .clear  (step_clear),
                .pulse  (step_pulse[gi]),
                .level  (step_level[gi]),
                .rise   (step_rise[gi])
            );
        end
    endgenerate

    always_comb begin
        nav_s1_d    = {bus.btn_left, bus.btn_right, bus.btn_edit};
        nav_s2_d    = nav_s1_q;
        nav_prev_d  = nav_s2_q;
        nav_vld_d   = {nav_vld_q[0], 1'b1};
        nav_armed_d = nav_armed_q | ({3{nav_vld_q[1]}} & ~nav_s2_q);

        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (nav_rise[0]) state_d = ST_EDIT_HH;
        end else if (nav_rise[0]) begin
            state_d = ST_IDLE;
        end else if (nav_rise[1]) begin
            case (state_q)
                ST_EDIT_HH: state_d = ST_EDIT_MM;
                ST_EDIT_MM: state_d = ST_EDIT_SS;
                default:    state_d = ST_EDIT_HH;
            endcase
        end else if (nav_rise[2]) begin
            case (state_q)
                ST_EDIT_HH: state_d = ST_EDIT_SS;
                ST_EDIT_MM: state_d = ST_EDIT_HH;
                default:    state_d = ST_EDIT_MM;
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
        end

        field_d   = field_of(state_d);
        editing_d = (state_d != ST_IDLE);

        // A held step button counts as continuous activity.
        if (state_q == ST_IDLE || (|nav_rise) || (|step_rise) || (|step_level))
            to_cnt_d = '0;
        else if (to_cnt_q != CNT_MAX)
            to_cnt_d = to_cnt_q + 1'b1;
        else
            to_cnt_d = to_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nav_s1_q    <= '0;
            nav_s2_q    <= '0;
            nav_prev_q  <= '0;
            nav_armed_q <= '0;
            nav_vld_q   <= '0;
            state_q     <= ST_IDLE;
            field_q     <= FIELD_NONE;
            editing_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            nav_s1_q    <= nav_s1_d;
            nav_s2_q    <= nav_s2_d;
            nav_prev_q  <= nav_prev_d;
            nav_armed_q <= nav_armed_d;
            nav_vld_q   <= nav_vld_d;
            state_q     <= state_d;
            field_q     <= field_d;
            editing_q   <= editing_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.contadoresH = field_q;
    assign bus.editing     = editing_q;
    assign bus.Arriba      = step_pulse[0];
    assign bus.Abajo       = step_pulse[1];

endmodule

// File: tb/tb_timer_edit_ctrl.sv
// Directed bench for timer_edit_ctrl with short hold/repeat/timeout values.
module tb_timer_edit_ctrl;
    import timer_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    timer_edit_ctrl_if bus ();

    timer_edit_ctrl #(
        .HOLD_DELAY    (10),
        .REPEAT_PERIOD (4),
        .TIMEOUT       (100),
        .CNT_W         (30)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_nav(input int which, input logic v);
        case (which)
            0:       bus.btn_edit = v;
            1:       bus.btn_right = v;
            2:       bus.btn_left = v;
            default: begin bus.btn_right = v; bus.btn_left = v; end
        endcase
    endtask

    // Press a navigation button: field must be unchanged 2 cycles in, updated on the 3rd.
    task automatic press(input int which, input logic [3:0] exp_before,
                         input logic [3:0] exp_after, input string tag);
        set_nav(which, 1'b1);
        repeat (2) tick();
        check({tag, "_early"}, 32'(bus.contadoresH), 32'(exp_before));
        tick();
        check(tag, 32'(bus.contadoresH), 32'(exp_after));
        check({tag, "_editing"}, 32'(bus.editing), 32'(exp_after != FIELD_NONE));
        repeat (2) tick();
        set_nav(which, 1'b0);
        repeat (3) tick();
        $display("tb: %s -> field %0d", tag, bus.contadoresH);
    endtask

    int   up_ticks [6] = '{3, 13, 17, 21, 25, 29};
    logic exp_up;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.btn_edit = 1'b0; bus.btn_right = 1'b0; bus.btn_left = 1'b0;
        bus.btn_up = 1'b0;   bus.btn_down = 1'b0;
        repeat (2) tick();
        check("rst_field",   32'(bus.contadoresH), 32'(FIELD_NONE));
        check("rst_editing", 32'(bus.editing), 32'd0);
        check("rst_arriba",  32'(bus.Arriba), 32'd0);
        check("rst_abajo",   32'(bus.Abajo), 32'd0);
        reset = 1'b1;
        repeat (4) tick();
        $display("tb: reset released");

        press(0, FIELD_NONE, FIELD_T_HH, "edit_enter");
        press(0, FIELD_T_HH, FIELD_NONE, "edit_exit");
        press(0, FIELD_NONE, FIELD_T_HH, "edit_enter2");
        press(1, FIELD_T_HH, FIELD_T_MM, "right_hh_mm");
        press(1, FIELD_T_MM, FIELD_T_SS, "right_mm_ss");
        press(1, FIELD_T_SS, FIELD_T_HH, "right_ss_hh");
        press(2, FIELD_T_HH, FIELD_T_SS, "left_hh_ss");
        press(3, FIELD_T_SS, FIELD_T_HH, "both_ss_hh");
        press(2, FIELD_T_HH, FIELD_T_SS, "left_hh_ss2");

        // Hold up in EDIT_SS: initial pulse, then HOLD_DELAY, then every REPEAT_PERIOD.
        bus.btn_up = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            exp_up = 1'b0;
            for (int k = 0; k < 6; k++) if (up_ticks[k] == i) exp_up = 1'b1;
            check("up_repeat", 32'(bus.Arriba), 32'(exp_up));
            check("up_repeat_abajo", 32'(bus.Abajo), 32'd0);
            if (i == 30) bus.btn_up = 1'b0;
        end
        check("up_repeat_field", 32'(bus.contadoresH), 32'(FIELD_T_SS));
        $display("tb: up hold/repeat in SS done");

        press(1, FIELD_T_SS, FIELD_T_HH, "right_ss_hh2");
        press(1, FIELD_T_HH, FIELD_T_MM, "right_hh_mm2");

        // Down held, up joins 5 cycles later: one Abajo only, then none after up releases.
        bus.btn_down = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("dn_up_abajo", 32'(bus.Abajo), 32'(i == 3));
            check("dn_up_arriba", 32'(bus.Arriba), 32'd0);
            if (i == 5)  bus.btn_up = 1'b1;
            if (i == 20) bus.btn_up = 1'b0;
        end
        bus.btn_down = 1'b0;
        repeat (3) tick();
        bus.btn_down = 1'b1;
        repeat (2) tick();
        check("dn_rerise_early", 32'(bus.Abajo), 32'd0);
        tick();
        check("dn_rerise", 32'(bus.Abajo), 32'd1);
        tick();
        check("dn_rerise_once", 32'(bus.Abajo), 32'd0);
        bus.btn_down = 1'b0;
        repeat (3) tick();
        check("dn_field", 32'(bus.contadoresH), 32'(FIELD_T_MM));
        $display("tb: down/up overlap in MM done");

        press(2, FIELD_T_MM, FIELD_T_HH, "left_mm_hh");

        // Up held in HH, right pressed mid-hold: field moves, stepping stops.
        bus.btn_up = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            check("hold_right_arriba", 32'(bus.Arriba), 32'(i == 3));
            if (i == 6) bus.btn_right = 1'b1;
            if (i == 8) check("hold_right_early", 32'(bus.contadoresH), 32'(FIELD_T_HH));
            if (i == 9) begin
                check("hold_right_field", 32'(bus.contadoresH), 32'(FIELD_T_MM));
                bus.btn_right = 1'b0;
            end
        end
        bus.btn_up = 1'b0;
        repeat (3) tick();
        $display("tb: field change during up hold done");

        press(0, FIELD_T_MM, FIELD_NONE, "edit_exit2");

        bus.btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("idle_up_arriba", 32'(bus.Arriba), 32'd0);
            check("idle_up_editing", 32'(bus.editing), 32'd0);
        end
        bus.btn_up = 1'b0;
        repeat (3) tick();
        $display("tb: up in IDLE ignored");

        // Timeout: HH cycles 0..99 are editing, cycle 100 is back in IDLE.
        bus.btn_edit = 1'b1;
        repeat (3) tick();
        check("to_enter", 32'(bus.editing), 32'd1);
        repeat (2) tick();
        bus.btn_edit = 1'b0;
        repeat (97) tick();
        check("to_before", 32'(bus.editing), 32'd1);
        tick();
        check("to_after", 32'(bus.editing), 32'd0);
        check("to_after_field", 32'(bus.contadoresH), 32'(FIELD_NONE));
        repeat (3) tick();
        $display("tb: inactivity timeout done");

        press(0, FIELD_NONE, FIELD_T_HH, "edit_enter3");
        bus.btn_up = 1'b1;
        repeat (16) tick();
        #2 reset = 1'b0;
        #1;
        check("arst_field",   32'(bus.contadoresH), 32'(FIELD_NONE));
        check("arst_editing", 32'(bus.editing), 32'd0);
        check("arst_arriba",  32'(bus.Arriba), 32'd0);
        check("arst_abajo",   32'(bus.Abajo), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("post_rst_arriba", 32'(bus.Arriba), 32'd0);
            check("post_rst_editing", 32'(bus.editing), 32'd0);
        end
        bus.btn_edit = 1'b1;
        repeat (3) tick();
        check("post_rst_enter", 32'(bus.contadoresH), 32'(FIELD_T_HH));
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("post_rst_held_up", 32'(bus.Arriba), 32'd0);
            if (i == 2) bus.btn_edit = 1'b0;
        end
        bus.btn_up = 1'b0;
        repeat (2) tick();
        $display("tb: async reset mid-repeat done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
